axi_lite_decerr_slave: RTL and testbench

- Default responder attached to the interconnect's error port.
- Completes every AXI-Lite transaction whose address the decoder flagged as decerr, so an unmapped access never hangs the master.
- Returns DECERR (2'b11) on B and R, zero read data, and keeps saturating error counters plus the last offending address for debug.
- Write and read channels are fully independent.

---
 rtl/axi_lite_decerr_slave.sv | 115 +++++++++++
 tb/tb_axi_lite_decerr_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_decerr_slave.sv
// AXI-Lite default slave: completes every access routed to it with DECERR,
// returns zero read data, and records saturating error counts plus the last offending address.
module axi_lite_decerr_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [CNT_WIDTH-1:0]    wr_err_count,
  output logic [CNT_WIDTH-1:0]    rd_err_count,
  output logic [ADDR_WIDTH-1:0]   last_err_addr
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;
  logic [CNT_WIDTH-1:0]  wr_cnt_reg, wr_cnt_next;
  logic [CNT_WIDTH-1:0]  rd_cnt_reg, rd_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic aw_hs, w_hs, ar_hs;

  // Write payload is accepted and dropped; the reduction only keeps the ports referenced.
  logic unused_inputs;
  assign unused_inputs = ^{s_wdata, s_wstrb};

  assign s_bresp = 2'b11;
  assign s_rresp = 2'b11;
  assign s_rdata = '0;

  assign wr_err_count  = wr_cnt_reg;
  assign rd_err_count  = rd_cnt_reg;
  assign last_err_addr = addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      addr_reg    <= '0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      wr_cnt_reg  <= wr_cnt_next;
      rd_cnt_reg  <= rd_cnt_next;
      addr_reg    <= addr_next;
    end
  end

  // Readies and valids are forced low while reset is held so nothing handshakes mid-reset.
  always_comb begin
    s_awready    = !rst && (w_state_reg == W_IDLE || w_state_reg == W_HAVE_W);
    s_wready     = !rst && (w_state_reg == W_IDLE || w_state_reg == W_HAVE_AW);
    s_bvalid     = !rst && (w_state_reg == W_RESP);
    s_arready    = !rst && (r_state_reg == R_IDLE);
    s_rvalid     = !rst && (r_state_reg == R_RESP);
    aw_hs        = s_awvalid && s_awready;
    w_hs         = s_wvalid && s_wready;
    ar_hs        = s_arvalid && s_arready;
    w_state_next = w_state_reg;
    r_state_next = r_state_reg;

    unique case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_next = W_RESP;
        else if (aw_hs)    w_state_next = W_HAVE_AW;
        else if (w_hs)     w_state_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)     w_state_next = W_RESP;
      W_HAVE_W:  if (aw_hs)    w_state_next = W_RESP;
      W_RESP:    if (s_bready) w_state_next = W_IDLE;
      default:   w_state_next = W_IDLE;
    endcase

    unique case (r_state_reg)
      R_IDLE:  if (ar_hs)    r_state_next = R_RESP;
      R_RESP:  if (s_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Counters stick at all-ones; a read address wins over a simultaneous write address.
  always_comb begin
    wr_cnt_next = wr_cnt_reg;
    rd_cnt_next = rd_cnt_reg;
    addr_next   = addr_reg;
    if (aw_hs && wr_cnt_reg != CNT_MAX) wr_cnt_next = wr_cnt_reg + 1'b1;
    if (ar_hs && rd_cnt_reg != CNT_MAX) rd_cnt_next = rd_cnt_reg + 1'b1;
    if (ar_hs)      addr_next = s_araddr;
    else if (aw_hs) addr_next = s_awaddr;
  end

endmodule

// File: tb/tb_axi_lite_decerr_slave.sv
// Bench for axi_lite_decerr_slave: a cycle-level transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_axi_lite_decerr_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] s_awaddr = '0;
  logic s_awvalid = 1'b0;
  logic s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [DW/8-1:0] s_wstrb = '0;
  logic s_wvalid = 1'b0;
  logic s_wready;
  logic [1:0] s_bresp;
  logic s_bvalid;
  logic s_bready = 1'b0;
  logic [AW-1:0] s_araddr = '0;
  logic s_arvalid = 1'b0;
  logic s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0] s_rresp;
  logic s_rvalid;
  logic s_rready = 1'b0;
  logic [CW-1:0] wr_err_count;
  logic [CW-1:0] rd_err_count;
  logic [AW-1:0] last_err_addr;

  axi_lite_decerr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_err_count(wr_err_count), .rd_err_count(rd_err_count), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which halves of a write are held, whether a B or R response is owed,
  // plain integer counts clamped at the maximum, and the last recorded address.
  bit m_started = 0;
  bit m_have_aw = 0, m_have_w = 0, m_b = 0, m_r = 0;
  int m_wcnt = 0, m_rcnt = 0;
  logic [AW-1:0] m_addr = '0;

  function automatic bit m_awr(); return !m_have_aw && !m_b; endfunction
  function automatic bit m_wr();  return !m_have_w && !m_b;  endfunction
  function automatic bit m_arr(); return !m_r;               endfunction

  always @(posedge clk) begin
    bit aw_hs, w_hs, ar_hs, got_aw, got_w;
    if (rst) begin
      m_started <= 1;
      m_have_aw <= 0; m_have_w <= 0; m_b <= 0; m_r <= 0;
      m_wcnt <= 0; m_rcnt <= 0; m_addr <= '0;
    end else begin
      aw_hs  = s_awvalid && m_awr();
      w_hs   = s_wvalid && m_wr();
      ar_hs  = s_arvalid && m_arr();
      got_aw = m_have_aw || aw_hs;
      got_w  = m_have_w || w_hs;
      if (m_b) begin
        if (s_bready) m_b <= 0;
      end else if (got_aw && got_w) begin
        m_b <= 1; m_have_aw <= 0; m_have_w <= 0;
      end else begin
        m_have_aw <= got_aw; m_have_w <= got_w;
      end
      if (m_r && s_rready) m_r <= 0;
      else if (ar_hs) m_r <= 1;
      if (aw_hs) m_wcnt <= (m_wcnt + 1 > CMAX) ? CMAX : m_wcnt + 1;
      if (ar_hs) m_rcnt <= (m_rcnt + 1 > CMAX) ? CMAX : m_rcnt + 1;
      if (ar_hs) m_addr <= s_araddr;
      else if (aw_hs) m_addr <= s_awaddr;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("m_awready", s_awready, !rst && m_awr());
      chk("m_wready", s_wready, !rst && m_wr());
      chk("m_arready", s_arready, !rst && m_arr());
      chk("m_bvalid", s_bvalid, !rst && m_b);
      chk("m_rvalid", s_rvalid, !rst && m_r);
      chk("m_bresp", s_bresp, 2'b11);
      chk("m_rresp", s_rresp, 2'b11);
      chk("m_rdata", s_rdata, '0);
      chk("m_wr_cnt", wr_err_count, m_wcnt);
      chk("m_rd_cnt", rd_err_count, m_rcnt);
      chk("m_last_addr", last_err_addr, m_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_rd [5] = '{1, 2, 3, 3, 3};

  initial begin
    step(); step();
    rst = 0;
    step();
    chk("post_reset_awready", s_awready, 1);
    chk("post_reset_wready", s_wready, 1);
    chk("post_reset_arready", s_arready, 1);

    // Simultaneous AW+W, bready high
    s_awaddr = 32'h0000_8000; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
    s_wvalid = 1; s_bready = 1;
    step();
    s_awvalid = 0; s_wvalid = 0;
    chk("t1_bvalid", s_bvalid, 1);
    chk("t1_bresp", s_bresp, 2'b11);
    chk("t1_wr_cnt", wr_err_count, 1);
    chk("t1_addr", last_err_addr, 32'h0000_8000);
    step();
    chk("t1_bvalid_done", s_bvalid, 0);
    $display("txn write addr=0x00008000 aw+w together");

    // W first, AW three cycles later, B stalled
    s_bready = 0; s_wvalid = 1; s_wdata = 32'h1234_5678;
    step();
    s_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_awready", s_awready, 1);
      chk("t2_wait_wready", s_wready, 0);
      if (i < 2) step();
    end
    s_awaddr = 32'h0001_0004; s_awvalid = 1;
    step();
    s_awvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_bvalid_stall", s_bvalid, 1);
      step();
    end
    chk("t2_bvalid_still", s_bvalid, 1);
    s_bready = 1;
    step();
    chk("t2_bvalid_done", s_bvalid, 0);
    chk("t2_wr_cnt", wr_err_count, 2);
    chk("t2_addr", last_err_addr, 32'h0001_0004);
    $display("txn write addr=0x00010004 w before aw");

    // Read with rready stall
    s_araddr = 32'h0000_4000; s_arvalid = 1; s_rready = 0;
    step();
    s_arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_rvalid", s_rvalid, 1);
      chk("t3_arready", s_arready, 0);
      chk("t3_rdata", s_rdata, 0);
      step();
    end
    s_rready = 1;
    step();
    chk("t3_rvalid_done", s_rvalid, 0);
    chk("t3_rd_cnt", rd_err_count, 1);
    $display("txn read addr=0x00004000 rready stalled");

    // Concurrent write and read; read address wins
    s_awaddr = 32'h1111_0000; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 32'h2222_0000; s_arvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("t4_bvalid", s_bvalid, 1);
    chk("t4_rvalid", s_rvalid, 1);
    chk("t4_addr", last_err_addr, 32'h2222_0000);
    chk("t4_wr_cnt", wr_err_count, 3);
    chk("t4_rd_cnt", rd_err_count, 2);
    step();
    $display("txn write 0x11110000 and read 0x22220000 together");

    // Saturation: five reads after reset
    rst = 1; step(); rst = 0; step();
    for (int i = 0; i < 5; i++) begin
      s_araddr = 32'h3000 + 32'(i * 4); s_arvalid = 1;
      step();
      s_arvalid = 0;
      chk("t5_rd_cnt", rd_err_count, exp_rd[i]);
      step();
      $display("txn read %0d count=%0d", i, rd_err_count);
    end

    // Reset while holding only the write address
    s_bready = 1; s_awaddr = 32'h0000_5000; s_awvalid = 1;
    step();
    s_awvalid = 0;
    chk("t6_have_aw_awready", s_awready, 0);
    rst = 1;
    #1;
    chk("t6_rst_awready", s_awready, 0);
    chk("t6_rst_wready", s_wready, 0);
    chk("t6_rst_arready", s_arready, 0);
    step();
    chk("t6_bvalid", s_bvalid, 0);
    chk("t6_wr_cnt", wr_err_count, 0);
    chk("t6_rd_cnt", rd_err_count, 0);
    rst = 0;
    step();
    s_awaddr = 32'h0000_6000; s_awvalid = 1; s_wvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0;
    chk("t6_fresh_bvalid", s_bvalid, 1);
    step();
    chk("t6_fresh_done", s_bvalid, 0);
    chk("t6_fresh_cnt", wr_err_count, 1);
    step();
    chk("t6_no_extra_b", s_bvalid, 0);
    $display("txn reset mid-write then write addr=0x00006000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
